// File: rtl/msg_frame_tx.sv
// msg_frame_tx: transmit-side message framer for the UART link.
// Buffers up to MAXBYTES payload bytes. On msg_send it emits
// SYNC, byte count, body (and an optional tail) through the UART load handshake.
// SYNC and ESC values in the count or body are preceded by ESC.
// Optional feature macro: MSG_FRAME_TAIL_EN appends SP_END after the body.
module msg_frame_tx #(
    parameter int unsigned MAXBYTES = 10,
    parameter logic [7:0]  SP_SYNC  = 8'h7E,
    parameter logic [7:0]  SP_ESC   = 8'hFE,
    parameter logic [7:0]  SP_END   = 8'h03
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       msg_wr,
    input  logic [7:0] msg_wdata,
    input  logic       msg_send,
    input  logic       tx_empty,
    output logic       ld_tx_data,
    output logic [7:0] tx_data,
    output logic       tx_enable,
    output logic       busy,
    output logic       done,
    output logic [3:0] msg_cnt
);

    localparam int unsigned PTR_W = $clog2(MAXBYTES + 1);
    localparam int unsigned CNT_W = 4;
`ifdef MSG_FRAME_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_BCNT,
        S_BODY,
        S_TAIL,
        S_DONE
    } state_t;

    // LOAD: wait for tx_empty, strobe the byte; ACK: wait for the UART to take it.
    typedef enum logic {
        PH_LOAD,
        PH_ACK
    } phase_t;

    state_t             state, state_n;
    phase_t             phase, phase_n;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_n;
    logic               esc_pend, esc_pend_n;
    logic               ld_n;
    logic [7:0]         tx_data_n;
    logic               tx_enable_n;
    logic               busy_n;
    logic               done_n;

    logic [7:0]         mem [MAXBYTES];
    logic               wr_ok;
    logic [7:0]         cur_byte;
    logic               need_esc;
    logic [7:0]         load_byte;
    logic [PTR_W-1:0]   rd_ptr_inc;

    assign msg_cnt = CNT_W'(wr_ptr);

    // Buffer writes are accepted only in IDLE and while space remains.
    assign wr_ok = msg_wr && (state == S_IDLE) && (wr_ptr < PTR_W'(MAXBYTES));

    // Payload storage; contents need no reset.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr] <= msg_wdata;
        end
    end

    // Byte currently being framed and whether it still needs its escape prefix.
    always_comb begin
        rd_ptr_inc = rd_ptr + PTR_W'(1);
        cur_byte   = (state == S_BCNT) ? 8'(wr_ptr) : mem[rd_ptr];
        need_esc   = ((state == S_BCNT) || (state == S_BODY)) && !esc_pend &&
                     ((cur_byte == SP_SYNC) || (cur_byte == SP_ESC));
        case (state)
            S_SYNC:  load_byte = SP_SYNC;
            S_TAIL:  load_byte = SP_END;
            default: load_byte = need_esc ? SP_ESC : cur_byte;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            phase      <= PH_LOAD;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            esc_pend   <= 1'b0;
            ld_tx_data <= 1'b0;
            tx_data    <= 8'h00;
            tx_enable  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            esc_pend   <= esc_pend_n;
            ld_tx_data <= ld_n;
            tx_data    <= tx_data_n;
            tx_enable  <= tx_enable_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        wr_ptr_n    = wr_ok ? (wr_ptr + PTR_W'(1)) : wr_ptr;
        rd_ptr_n    = rd_ptr;
        esc_pend_n  = esc_pend;
        ld_n        = 1'b0;
        tx_data_n   = tx_data;
        tx_enable_n = tx_enable;
        busy_n      = busy;
        done_n      = 1'b0;

        case (state)
            S_IDLE: begin
                // A write in the same cycle counts toward a non-empty buffer.
                if (msg_send && ((wr_ptr != '0) || wr_ok)) begin
                    state_n     = S_SYNC;
                    phase_n     = PH_LOAD;
                    rd_ptr_n    = '0;
                    esc_pend_n  = 1'b0;
                    busy_n      = 1'b1;
                    tx_enable_n = 1'b1;
                end
            end

            S_SYNC, S_BCNT, S_BODY, S_TAIL: begin
                if (phase == PH_LOAD) begin
                    if (tx_empty) begin
                        ld_n      = 1'b1;
                        tx_data_n = load_byte;
                        phase_n   = PH_ACK;
                    end
                end else if (!tx_empty) begin
                    phase_n = PH_LOAD;
                    if (need_esc) begin
                        // Escape prefix taken; resend the same byte raw.
                        esc_pend_n = 1'b1;
                    end else begin
                        esc_pend_n = 1'b0;
                        case (state)
                            S_SYNC: state_n = S_BCNT;
                            S_BCNT: state_n = S_BODY;
                            S_BODY: begin
                                if (rd_ptr_inc == wr_ptr) begin
                                    if (TAIL_EN) begin
                                        state_n = S_TAIL;
                                    end else begin
                                        state_n = S_DONE;
                                        done_n  = 1'b1;
                                    end
                                end else begin
                                    rd_ptr_n = rd_ptr_inc;
                                end
                            end
                            default: begin
                                state_n = S_DONE;
                                done_n  = 1'b1;
                            end
                        endcase
                    end
                end
            end

            S_DONE: begin
                state_n     = S_IDLE;
                phase_n     = PH_LOAD;
                wr_ptr_n    = '0;
                rd_ptr_n    = '0;
                esc_pend_n  = 1'b0;
                busy_n      = 1'b0;
                tx_enable_n = 1'b0;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_msg_frame_tx.sv
// Testbench for msg_frame_tx: scoreboard of expected frame bytes with a simple UART model.
module tb_msg_frame_tx;

    logic       CLK;
    logic       reset;
    logic       msg_wr;
    logic [7:0] msg_wdata;
    logic       msg_send;
    logic       tx_empty;
    logic       ld_tx_data;
    logic [7:0] tx_data;
    logic       tx_enable;
    logic       busy;
    logic       done;
    logic [3:0] msg_cnt;

    int         n_checks;
    int         n_errors;
    int         n_loads;
    int         n_done;
    bit         hold;
    logic [7:0] exp_q[$];
    logic [7:0] model_buf[$];

    msg_frame_tx dut (
        .CLK        (CLK),
        .reset      (reset),
        .msg_wr     (msg_wr),
        .msg_wdata  (msg_wdata),
        .msg_send   (msg_send),
        .tx_empty   (tx_empty),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .busy       (busy),
        .done       (done),
        .msg_cnt    (msg_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every load strobe must see an idle UART.
    initial begin
        forever begin
            @(negedge CLK);
            if (ld_tx_data) begin
                n_loads++;
                check_eq("tx_empty_at_load", 32'(tx_empty), 32'd1);
            end
            if (done) n_done++;
        end
    end

    // UART model: takes a byte, drops tx_empty 3 cycles later, idles again 4 cycles after that.
    initial begin
        logic [7:0] e;
        tx_empty = 1'b1;
        forever begin
            @(negedge CLK);
            if (ld_tx_data) begin
                if (exp_q.size() == 0) begin
                    check_eq("frame_byte_avail", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("frame_byte", 32'(tx_data), 32'(e));
                end
                repeat (3) @(negedge CLK);
                tx_empty = 1'b0;
                repeat (4) @(negedge CLK);
                while (hold) @(negedge CLK);
                tx_empty = 1'b1;
            end
        end
    end

    task automatic push_esc(input logic [7:0] b);
        if (b == 8'h7E || b == 8'hFE) exp_q.push_back(8'hFE);
        exp_q.push_back(b);
    endtask

    // Expected frame from the bench's own copy of the buffer.
    task automatic push_frame();
        if (model_buf.size() == 0) return;
        exp_q.push_back(8'h7E);
        push_esc(8'(model_buf.size()));
        foreach (model_buf[i]) push_esc(model_buf[i]);
`ifdef MSG_FRAME_TAIL_EN
        exp_q.push_back(8'h03);
`endif
        model_buf.delete();
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge CLK);
        msg_wr    = 1'b1;
        msg_wdata = b;
        if (model_buf.size() < 10) model_buf.push_back(b);
        @(negedge CLK);
        msg_wr = 1'b0;
    endtask

    task automatic send_frame(input string tag);
        @(negedge CLK);
        msg_send = 1'b1;
        push_frame();
        @(negedge CLK);
        msg_send = 1'b0;
        check_eq({tag, "_busy_on"}, 32'(busy), 32'd1);
        check_eq({tag, "_txen_on"}, 32'(tx_enable), 32'd1);
    endtask

    task automatic write_and_send(input string tag, input logic [7:0] b);
        @(negedge CLK);
        msg_wr    = 1'b1;
        msg_wdata = b;
        msg_send  = 1'b1;
        model_buf.push_back(b);
        push_frame();
        @(negedge CLK);
        msg_wr   = 1'b0;
        msg_send = 1'b0;
        check_eq({tag, "_busy_on"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_frame(input string tag, input int done_base);
        int cyc;
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
        end
        check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
        @(negedge CLK);
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_busy_off"}, 32'(busy), 32'd0);
        check_eq({tag, "_txen_off"}, 32'(tx_enable), 32'd0);
        check_eq({tag, "_cnt_clr"}, 32'(msg_cnt), 32'd0);
        check_eq({tag, "_done_cnt"}, 32'(n_done - done_base), 32'd1);
        check_eq({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle_send_check(input string tag);
        int l0;
        int busy_hits;
        l0 = n_loads;
        busy_hits = 0;
        @(negedge CLK);
        msg_send = 1'b1;
        push_frame();
        @(negedge CLK);
        msg_send = 1'b0;
        repeat (10) begin
            if (busy) busy_hits++;
            @(negedge CLK);
        end
        check_eq({tag, "_no_load"}, 32'(n_loads - l0), 32'd0);
        check_eq({tag, "_no_busy"}, 32'(busy_hits), 32'd0);
    endtask

    task automatic wait_loads(input string tag, input int target);
        int cyc;
        cyc = 0;
        while (n_loads < target && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
        end
        check_eq({tag, "_load_reached"}, 32'(n_loads >= target), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ld"}, 32'(ld_tx_data), 32'd0);
        check_eq({tag, "_data"}, 32'(tx_data), 32'd0);
        check_eq({tag, "_txen"}, 32'(tx_enable), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_cnt"}, 32'(msg_cnt), 32'd0);
    endtask

    initial begin
        int base;
        int ld_hits;
        int cyc;
        n_checks  = 0;
        n_errors  = 0;
        n_loads   = 0;
        n_done    = 0;
        hold      = 1'b0;
        reset     = 1'b0;
        msg_wr    = 1'b0;
        msg_wdata = 8'h00;
        msg_send  = 1'b0;

        repeat (3) @(negedge CLK);
        check_outputs_zero("rst");
        reset = 1'b1;

        // Plain frame.
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        check_eq("t1_cnt", 32'(msg_cnt), 32'd3);
        base = n_done;
        send_frame("t1");
        wait_frame("t1", base);

        // Escaped body bytes.
        write_byte(8'h7E);
        write_byte(8'hFE);
        write_byte(8'h05);
        base = n_done;
        send_frame("t2");
        wait_frame("t2", base);

        // Full buffer; the 11th write is dropped.
        for (int i = 0; i < 11; i++) write_byte(8'(8'h40 + i));
        check_eq("t3_cnt_full", 32'(msg_cnt), 32'd10);
        base = n_done;
        send_frame("t3");
        wait_frame("t3", base);

        // Empty send does nothing.
        idle_send_check("t4_empty");

        // UART stalls during the body.
        for (int i = 1; i <= 4; i++) write_byte(8'(i));
        base = n_done;
        send_frame("t5");
        wait_loads("t5", n_loads + 3);
        hold = 1'b1;
        cyc = 0;
        while (tx_empty && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        check_eq("t5_stall_seen", 32'(tx_empty), 32'd0);
        ld_hits = 0;
        repeat (20) begin
            @(negedge CLK);
            if (ld_tx_data) ld_hits++;
        end
        check_eq("t5_no_load_stall", 32'(ld_hits), 32'd0);
        check_eq("t5_busy_stall", 32'(busy), 32'd1);
        hold = 1'b0;
        wait_frame("t5", base);

        // Reset during body byte 2.
        write_byte(8'hA1);
        write_byte(8'hA2);
        write_byte(8'hA3);
        send_frame("t6");
        wait_loads("t6", n_loads + 4);
        reset = 1'b0;
        #1;
        check_outputs_zero("t6_abort");
        exp_q.delete();
        model_buf.delete();
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        cyc = 0;
        while (!tx_empty && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        check_eq("t6_cnt_after", 32'(msg_cnt), 32'd0);
        idle_send_check("t6_post");

        // Same-cycle write and send; 03 is not escaped in the body.
        base = n_done;
        write_and_send("t7", 8'h03);
        wait_frame("t7", base);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
